// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester round-robin mux arbiter.
// Optional burst locking is enabled by defining ARB_BURST_EN.
package mux_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int W_DEF         = 5;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Requester/consumer bundle of the 2:1 mux arbiter.
// slave = arbiter side, master = requesters plus consumer.
interface mux2_rr_arbiter_if #(
    parameter int W = 5
) ();

    logic         req0;
    logic [W-1:0] I0;
    logic         lock0;
    logic         gnt0;
    logic         req1;
    logic [W-1:0] I1;
    logic         lock1;
    logic         gnt1;
    logic         o_valid;
    logic         o_ready;
    logic [W-1:0] o;
    logic         sel;

    modport slave (
        input  req0, I0, lock0,
        input  req1, I1, lock1,
        input  o_ready,
        output gnt0, gnt1,
        output o_valid, o, sel
    );

    modport master (
        output req0, I0, lock0,
        output req1, I1, lock1,
        output o_ready,
        input  gnt0, gnt1,
        input  o_valid, o, sel
    );

endinterface

// File: rtl/mux2_rr_arbiter_rr_pick2.sv
// Two-way round-robin pick with an owner override.
// Shared by the plain grant path and the burst-lock override.
module rr_pick2
    import mux_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic force_owner_valid,
    input  logic force_owner,
    output logic winner,
    output logic any_req
);

    // Override first, then the requester not granted last on a tie.
    always_comb begin
        any_req = req0 | req1;
        winner  = REQ0;
        if (force_owner_valid)
            winner = force_owner;
        else if (req0 & req1)
            winner = ~last;
        else if (req1)
            winner = REQ1;
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving a registered 2:1 W-bit mux slot.
// Define ARB_BURST_EN to let the owner hold grants via lock0/lock1.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mux2_rr_arbiter_if.slave   bus
);

    state_t       st;
    state_t       st_nx;
    logic         last;
    logic         winner;
    logic         any_req;
    logic         can_load;
    logic         load;
    logic         force_v;
    logic [W-1:0] o_q;
    logic         sel_q;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt;
    logic          own_req;
    logic          own_lock;
    logic          win_lock;

    // The current owner keeps the slot while locked and under budget.
    always_comb begin
        own_req  = last ? bus.req1 : bus.req0;
        own_lock = last ? bus.lock1 : bus.lock0;
        win_lock = winner ? bus.lock1 : bus.lock0;
        force_v  = own_req & own_lock & (cnt < CW'(MAX_BURST));
    end

    // Count locked back-to-back grants; saturate when the other side idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load) begin
            if ((winner == last) && win_lock) begin
                if (cnt != CW'(MAX_BURST))
                    cnt <= cnt + 1'b1;
            end else
                cnt <= CW'(1);
        end
    end
`else
    localparam int max_burst_unused = MAX_BURST;

    logic unused_lock;

    assign unused_lock = bus.lock0 ^ bus.lock1;
    assign force_v     = 1'b0;
`endif

    rr_pick2 u_pick (
        .req0              (bus.req0),
        .req1              (bus.req1),
        .last              (last),
        .force_owner_valid (force_v),
        .force_owner       (last),
        .winner            (winner),
        .any_req           (any_req)
    );

    // Grant only when the slot can take data; silent while in reset.
    always_comb begin
        can_load = (st == ST_EMPTY) | bus.o_ready;
        load     = can_load & any_req & rst_n;
        bus.gnt0 = load & (winner == REQ0);
        bus.gnt1 = load & (winner == REQ1);
    end

    // Slot occupancy: a load fills it, a drain with no load empties it.
    always_comb begin
        st_nx = st;
        if (load)
            st_nx = ST_FULL;
        else if ((st == ST_FULL) && bus.o_ready)
            st_nx = ST_EMPTY;
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= ST_EMPTY;
        else
            st <= st_nx;
    end

    // Operand, owner and round-robin pointer change only on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q   <= '0;
            sel_q <= REQ0;
            last  <= REQ1;
        end else if (load) begin
            o_q   <= winner ? bus.I1 : bus.I0;
            sel_q <= winner;
            last  <= winner;
        end
    end

    assign bus.o_valid = (st == ST_FULL);
    assign bus.o       = o_q;
    assign bus.sel     = sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter.
// Burst expectations follow ARB_BURST_EN when it is defined.
module tb_mux2_rr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [5:0] lock_seq;

    mux2_rr_arbiter_if #(.W(5)) bus ();

    mux2_rr_arbiter #(
        .W         (5),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input logic v,
                        input logic [4:0] d, input logic s);
        chk({tag, "_valid"}, {7'd0, bus.o_valid}, {7'd0, v});
        chk({tag, "_o"}, {3'd0, bus.o}, {3'd0, d});
        chk({tag, "_sel"}, {7'd0, bus.sel}, {7'd0, s});
    endtask

    task automatic gnts(input string tag, input logic g0, input logic g1);
        chk({tag, "_gnt0"}, {7'd0, bus.gnt0}, {7'd0, g0});
        chk({tag, "_gnt1"}, {7'd0, bus.gnt1}, {7'd0, g1});
        chk({tag, "_excl"}, {7'd0, bus.gnt0 & bus.gnt1}, 8'd0);
    endtask

    task automatic grant_step(input string tag, input logic w);
        #1;
        gnts(tag, ~w, w);
        @(posedge clk);
        #1;
        slot(tag, 1'b1, w ? 5'h15 : 5'h0A, w);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.req0    = 1'b0;
        bus.req1    = 1'b0;
        bus.lock0   = 1'b0;
        bus.lock1   = 1'b0;
        bus.I0      = '0;
        bus.I1      = '0;
        bus.o_ready = 1'b0;
`ifdef ARB_BURST_EN
        lock_seq = 6'b010000;
`else
        lock_seq = 6'b101010;
`endif

        #20;
        bus.req0    = 1'b1;
        bus.I0      = 5'h01;
        bus.o_ready = 1'b1;
        #1;
        slot("rst", 1'b0, 5'h00, 1'b0);
        gnts("rst", 1'b0, 1'b0);

        #79;
        rst_n = 1'b1;
        #1;
        gnts("single", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        slot("single", 1'b1, 5'h01, 1'b0);
        bus.req0 = 1'b0;
        #1;
        gnts("idle", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        slot("drain", 1'b0, 5'h01, 1'b0);

        bus.o_ready = 1'b0;
        bus.req0    = 1'b1;
        bus.I0      = 5'h0A;
        #1;
        gnts("empty_load", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        slot("empty_load", 1'b1, 5'h0A, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.I1   = 5'h1F;
        repeat (3) begin
            #1;
            gnts("bp", 1'b0, 1'b0);
            @(posedge clk);
            #1;
            slot("bp", 1'b1, 5'h0A, 1'b0);
        end
        bus.o_ready = 1'b1;
        #1;
        gnts("bp_release", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        slot("bp_release", 1'b1, 5'h1F, 1'b1);

        bus.o_ready = 1'b0;
        bus.I1      = 5'h1C;
        bus.req0    = 1'b1;
        bus.I0      = 5'h03;
        #1;
        gnts("cancel_bp", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        slot("cancel_bp", 1'b1, 5'h1F, 1'b1);
        bus.req1    = 1'b0;
        bus.o_ready = 1'b1;
        #1;
        gnts("cancel", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        slot("cancel", 1'b1, 5'h03, 1'b0);

        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.I1   = 5'h15;
        #1;
        gnts("load15", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        slot("load15", 1'b1, 5'h15, 1'b1);
        bus.req1    = 1'b0;
        bus.o_ready = 1'b0;

        #1;
        rst_n = 1'b0;
        #1;
        slot("midrst", 1'b0, 5'h00, 1'b0);
        gnts("midrst", 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;

        bus.req0    = 1'b1;
        bus.req1    = 1'b1;
        bus.I0      = 5'h0A;
        bus.I1      = 5'h15;
        bus.o_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            grant_step("tie", i[0]);

        bus.lock0 = 1'b1;
        for (int i = 0; i < 6; i++)
            grant_step("lock", lock_seq[i]);

        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.lock0 = 1'b0;
        @(posedge clk);
        #1;
        chk("final_drain", {7'd0, bus.o_valid}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
